// File: rtl/centroid_calc.sv
// Binary-image centroid engine: scans one frame row by row, sums the set pixels inside
// a rectangular window, and divides the coordinate sums by the pixel count.
//
// state | meaning
// IDLE  | waiting for an iVSYNC rising edge; last result held
// SCAN  | issuing row reads 0..NUM_ROWS-1, accumulating the previous row
// DRAIN | accumulating the final row, deciding whether to divide
// DIV   | two restoring dividers, one quotient bit per cycle
// OUT   | result presented until iREADY
module centroid_calc #(
    parameter int ROW_WIDTH  = 640,
    parameter int NUM_ROWS   = 480,
    parameter int ADDR_WIDTH = 11,
    localparam int XW  = $clog2(ROW_WIDTH),
    localparam int YW  = $clog2(NUM_ROWS),
    localparam int S_W = $clog2(ROW_WIDTH * NUM_ROWS + 1),
    localparam int W_W = S_W + ((XW > YW) ? XW : YW)
) (
    input  logic                  CCLK,
    input  logic                  RST_N,
    input  logic                  iVSYNC,
    input  logic                  iABORT,
    input  logic [XW-1:0]         iX_MIN,
    input  logic [XW-1:0]         iX_MAX,
    input  logic [YW-1:0]         iY_MIN,
    input  logic [YW-1:0]         iY_MAX,
    input  logic [S_W-1:0]        iMIN_COUNT,
    output logic [ADDR_WIDTH-1:0] oADDR,
    output logic                  oRD_EN,
    input  logic [ROW_WIDTH-1:0]  iMEMIN,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic [XW-1:0]         oX,
    output logic [YW-1:0]         oY,
    output logic [S_W-1:0]        oSUM_S,
    output logic                  oFOUND,
    output logic                  oBUSY,
    output logic                  oOVERRUN,
    output logic [2:0]            oSTATE
);
    localparam int CW = $clog2(W_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        DRAIN = 3'd2,
        DIV   = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t         state;
    logic           vsync_q, vs_armed, rise;
    logic [XW-1:0]  x_min_q, x_max_q;
    logic [YW-1:0]  y_min_q, y_max_q;
    logic [S_W-1:0] min_q;
    logic [YW-1:0]  row, row_q;
    logic           rd_en, rd_q;
    logic [S_W-1:0] acc_s, row_s, s_nxt, dvs, rem_x, rem_y;
    logic [W_W-1:0] acc_x, acc_y, row_x, row_y, x_nxt, y_nxt, quo_x, quo_y;
    logic [CW-1:0]  dcnt;
    logic           y_ok, acc_en;
    logic [S_W+W_W-1:0] stp_x, stp_y;

    // vs_armed keeps a level that is already high at reset release from looking like an edge
    assign rise = vs_armed & iVSYNC & ~vsync_q;

    always_comb begin
        row_s = '0;
        row_x = '0;
        for (int x = 0; x < ROW_WIDTH; x++) begin
            if (iMEMIN[x] && (XW'(x) >= x_min_q) && (XW'(x) <= x_max_q)) begin
                row_s = row_s + S_W'(1);
                row_x = row_x + W_W'(x);
            end
        end
        row_y  = W_W'(row_s) * W_W'(row_q);
        y_ok   = (row_q >= y_min_q) && (row_q <= y_max_q);
        acc_en = rd_q && y_ok && (state == SCAN || state == DRAIN);
        s_nxt  = acc_en ? acc_s + row_s : acc_s;
        x_nxt  = acc_en ? acc_x + row_x : acc_x;
        y_nxt  = acc_en ? acc_y + row_y : acc_y;
    end

    function automatic logic [S_W+W_W-1:0] div_step(input logic [S_W-1:0] rem,
                                                     input logic [W_W-1:0] quo,
                                                     input logic [S_W-1:0] d);
        logic [S_W:0]   trial, diff;
        logic           ge;
        logic [S_W-1:0] rem_n;
        trial = {rem, quo[W_W-1]};
        diff  = trial - {1'b0, d};
        ge    = trial >= {1'b0, d};
        rem_n = ge ? diff[S_W-1:0] : trial[S_W-1:0];
        return {rem_n, quo[W_W-2:0], ge};
    endfunction

    assign stp_x = div_step(rem_x, quo_x, dvs);
    assign stp_y = div_step(rem_y, quo_y, dvs);

    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            vsync_q  <= 1'b0;
            vs_armed <= 1'b0;
            x_min_q  <= '0;
            x_max_q  <= '0;
            y_min_q  <= '0;
            y_max_q  <= '0;
            min_q    <= '0;
            row      <= '0;
            row_q    <= '0;
            rd_en    <= 1'b0;
            rd_q     <= 1'b0;
            acc_s    <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
            dvs      <= '0;
            rem_x    <= '0;
            rem_y    <= '0;
            quo_x    <= '0;
            quo_y    <= '0;
            dcnt     <= '0;
            oX       <= '0;
            oY       <= '0;
            oSUM_S   <= '0;
            oFOUND   <= 1'b0;
            oOVERRUN <= 1'b0;
        end else begin
            vsync_q  <= iVSYNC;
            vs_armed <= 1'b1;
            rd_q     <= rd_en;
            row_q    <= row;
            oOVERRUN <= rise && (state != IDLE);
            if (state == SCAN || state == DRAIN) begin
                acc_s <= s_nxt;
                acc_x <= x_nxt;
                acc_y <= y_nxt;
            end
            if (iABORT) begin
                state <= IDLE;
                rd_en <= 1'b0;
                row   <= '0;
            end else begin
                case (state)
                    IDLE: if (rise) begin
                        state   <= SCAN;
                        rd_en   <= 1'b1;
                        row     <= '0;
                        x_min_q <= iX_MIN;
                        x_max_q <= iX_MAX;
                        y_min_q <= iY_MIN;
                        y_max_q <= iY_MAX;
                        min_q   <= iMIN_COUNT;
                        acc_s   <= '0;
                        acc_x   <= '0;
                        acc_y   <= '0;
                    end
                    SCAN: if (row == YW'(NUM_ROWS - 1)) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                        row   <= '0;
                    end else begin
                        row <= row + 1'b1;
                    end
                    // decision uses the sums including the row arriving this cycle
                    DRAIN: if (s_nxt == '0 || s_nxt < min_q) begin
                        state  <= OUT;
                        oX     <= '0;
                        oY     <= '0;
                        oSUM_S <= s_nxt;
                        oFOUND <= 1'b0;
                    end else begin
                        state <= DIV;
                        dvs   <= s_nxt;
                        quo_x <= x_nxt;
                        quo_y <= y_nxt;
                        rem_x <= '0;
                        rem_y <= '0;
                        dcnt  <= CW'(W_W - 1);
                    end
                    DIV: begin
                        {rem_x, quo_x} <= stp_x;
                        {rem_y, quo_y} <= stp_y;
                        dcnt <= dcnt - 1'b1;
                        if (dcnt == '0) begin
                            state  <= OUT;
                            oX     <= stp_x[XW-1:0];
                            oY     <= stp_y[YW-1:0];
                            oSUM_S <= acc_s;
                            oFOUND <= 1'b1;
                        end
                    end
                    OUT: if (iREADY) state <= IDLE;
                    default: begin
                        state <= IDLE;
                        rd_en <= 1'b0;
                        row   <= '0;
                    end
                endcase
            end
        end
    end

    assign oADDR  = ADDR_WIDTH'(row);
    assign oRD_EN = rd_en;
    assign oVALID = (state == OUT);
    assign oBUSY  = (state != IDLE);
    assign oSTATE = state;
endmodule
